// File: rtl/commutation_sequencer.sv
// commutation_sequencer: six-step BLDC commutation from filtered hall inputs,
// with deadtime on every pattern change and sticky fault supervision.
module commutation_sequencer #(
    parameter int FILTER_CYCLES   = 4,
    parameter int DEADTIME_CYCLES = 8,
    parameter int STALL_CYCLES    = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        direction,
    input  logic        clear_fault,
    input  logic [2:0]  h,
    output logic [2:0]  u,
    output logic [2:0]  z,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [15:0] step_count
);
    typedef enum logic [1:0] {IDLE, DEADTIME, RUN, FAULT} state_t;
    state_t      state;
    logic [2:0]  s1, s2, cand, hall, prev;
    logic [7:0]  cnt, dt, n;
    logic [19:0] st;
    logic        dir_q, valid, chg, fwd, rev, skip, bad, stall;

    function automatic logic [2:0] idx(input logic [2:0] x);
        return x == 3'b101 ? 3'd0 : x == 3'b100 ? 3'd1 : x == 3'b110 ? 3'd2 :
               x == 3'b010 ? 3'd3 : x == 3'b011 ? 3'd4 : 3'd5;
    endfunction

    function automatic logic [2:0] nx(input logic [2:0] i);
        return i == 3'd5 ? 3'd0 : i + 3'd1;
    endfunction

    // {u,z}; reverse drives high whatever forward drives low
    function automatic logic [5:0] pattern(input logic [2:0] x, input logic d);
        logic [5:0] f;
        f = x == 3'b101 ? 6'b100_001 : x == 3'b100 ? 6'b100_010 : x == 3'b110 ? 6'b010_100 :
            x == 3'b010 ? 6'b010_001 : x == 3'b011 ? 6'b001_010 : 6'b001_100;
        return d ? {~(f[5:3] | f[2:0]), f[2:0]} : f;
    endfunction

    always_comb begin
        n     = s2 != cand ? 8'd1 : cnt == 8'hff ? cnt : cnt + 8'd1;
        valid = hall != 3'b000 && hall != 3'b111;
        chg   = hall != prev;
        fwd   = idx(hall) == nx(idx(prev));
        rev   = idx(prev) == nx(idx(hall));
        skip  = chg && valid && !fwd && !rev && (state == DEADTIME || state == RUN);
        bad   = !valid && !(state == IDLE && !enable);
        stall = state == RUN && st + 20'd1 == 20'(STALL_CYCLES);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            cnt  <= '0;
            hall <= '0;
        end else begin
            s1   <= h;
            s2   <= s1;
            cand <= s2;
            cnt  <= n;
            if (n >= 8'(FILTER_CYCLES))
                hall <= s2;
        end
    end

    // priority: invalid hall > skipped step > stall > clear_fault > enable=0 > change
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            {u, z}     <= 6'b000_111;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            step_count <= '0;
            dt         <= '0;
            st         <= '0;
            dir_q      <= 1'b0;
            prev       <= '0;
        end else begin
            prev <= hall;
            dt   <= '0;
            st   <= '0;
            if (state == FAULT) begin
                if (clear_fault && valid) begin
                    state      <= IDLE;
                    fault      <= 1'b0;
                    fault_code <= 2'b00;
                end
            end else if (bad || skip || stall) begin
                state      <= FAULT;
                fault      <= 1'b1;
                fault_code <= bad ? 2'b01 : skip ? 2'b11 : 2'b10;
                {u, z}     <= 6'b000_111;
            end else if (!enable || state == IDLE) begin
                state  <= enable ? DEADTIME : IDLE;
                {u, z} <= 6'b000_111;
            end else if (chg || (state == RUN && direction != dir_q)) begin
                state      <= DEADTIME;
                {u, z}     <= 6'b000_111;
                step_count <= chg ? step_count + (fwd ? 16'd1 : 16'hffff) : step_count;
            end else if (state == RUN) begin
                st <= st + 20'd1;
            end else if (dt == 8'(DEADTIME_CYCLES - 1)) begin
                state  <= RUN;
                {u, z} <= pattern(hall, direction);
                dir_q  <= direction;
            end else begin
                dt <= dt + 8'd1;
            end
        end
    end
endmodule

// File: doc/commutation_sequencer.md
COMMUTATION_SEQUENCER -- requirements
Module: commutation_sequencer

Interface
REQ-001 Parameter FILTER_CYCLES, default 4: consecutive identical synchronized hall samples needed to accept a new hall value (range 1-255).
REQ-002 Parameter DEADTIME_CYCLES, default 8: all-phases-float cycles inserted on every drive-pattern change (range 1-255).
REQ-003 Parameter STALL_CYCLES, default 50000: cycles without an accepted hall change in RUN before a stall fault (range 1 to 2^20-1).
REQ-004 clock  input  1  single clock; all flops rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  1 = commutate; 0 = float all phases, return to IDLE.
REQ-007 direction  input  1  0 = forward, 1 = reverse; sampled on each pattern update.
REQ-008 clear_fault  input  1  single-cycle pulse; leaves FAULT.
REQ-009 h  input  3  raw asynchronous hall inputs {h1,h2,h3}.
REQ-010 u  output  3  one-hot high-side phase {A,B,C}; registered.
REQ-011 z  output  3  phases held high-impedance; registered; phase with u=0 and z=0 is driven low.
REQ-012 fault  output  1  sticky fault flag.
REQ-013 fault_code  output  2  00 none, 01 invalid hall (000/111), 10 stall, 11 skipped step.
REQ-014 step_count  output  16  signed commutation counter.

Function
REQ-015 h SHALL pass through a 2-flop synchronizer; the filter SHALL accept a value after FILTER_CYCLES consecutive equal synchronized samples; total latency raw change to accepted value = 2 + FILTER_CYCLES cycles.
REQ-016 Forward table, accepted hall -> (u,z): 101->(100,001); 100->(100,010); 110->(010,100); 010->(010,001); 011->(001,010); 001->(001,100).
REQ-017 Reverse: z as forward; u = bitwise NOT(forward u OR forward z), i.e. high and low phases swapped.
REQ-018 Float pattern SHALL be u=000, z=111.
REQ-019 States: IDLE, DEADTIME, RUN, FAULT.
REQ-020 IDLE: float pattern; enable=1 with valid accepted hall -> DEADTIME; enable=1 with invalid hall -> FAULT code 01.
REQ-021 DEADTIME: float pattern for exactly DEADTIME_CYCLES cycles, then load table pattern for current accepted hall and direction -> RUN.
REQ-022 RUN: on accepted hall change or direction change -> DEADTIME starting next cycle; otherwise hold pattern.
REQ-023 Forward-adjacent accepted change (sequence 101,100,110,010,011,001, cyclic) SHALL increment step_count; reverse-adjacent SHALL decrement; two's-complement wrap at +32767/-32768, no saturation.
REQ-024 Valid non-adjacent change in RUN or DEADTIME -> FAULT code 11, step_count unchanged.
REQ-025 Accepted 000 or 111 in any state except IDLE-with-enable=0 -> FAULT code 01.
REQ-026 Stall counter SHALL clear on every accepted change and on entry to RUN; reaching STALL_CYCLES in RUN -> FAULT code 10.
REQ-027 FAULT: float pattern, fault=1, fault_code held; exit to IDLE only on clear_fault=1, which also clears fault and fault_code.
REQ-028 enable=0 in any non-FAULT state -> IDLE next cycle, float pattern; no fault.
REQ-029 Simultaneous events, priority: reset > invalid hall > skipped step > stall > clear_fault > enable=0 > hall/direction change.
REQ-030 Hall change during DEADTIME SHALL restart the deadtime count from zero; adjacent change updates step_count.
REQ-031 Float pattern SHALL appear on u/z the cycle after any change trigger; no cycle ever drives two old/new patterns back-to-back.

Reset
REQ-032 On reset assertion, asynchronously: state IDLE, u=000, z=111, fault=0, fault_code=00, step_count=0, synchronizer/filter/stall/deadtime counters 0.
REQ-033 Reset mid-deadtime or mid-fault SHALL fully abort; after release the block behaves as from power-up.

Verification
REQ-034 enable=1, h=101 steady, direction=0 -> float for 2+FILTER+DEADTIME window, then u=100, z=001; step_count=0.
REQ-035 Forward walk 101,100,110,010,011,001,101 -> each step shows 8 float cycles then table pattern; step_count=6.
REQ-036 direction=1, h=110 -> u=001, z=100; then h=100 -> step_count decrements by 1.
REQ-037 h=101 then h=010 (skip) -> fault=1, fault_code=11, u=000, z=111; clear_fault pulse -> IDLE, fault=0.
REQ-038 h glitch to 011 for FILTER_CYCLES-1 cycles -> no pattern change, no step; h=000 held -> fault_code=01.
REQ-039 RUN with h frozen STALL_CYCLES cycles -> fault_code=10; step_count=32767 plus forward step -> -32768.
